// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin A/B access controller and clear sequencer for the 8x8 synchronous ram.
module ram_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [2:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_gnt,
  output logic       a_done,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [2:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_gnt,
  output logic       b_done,
  output logic [7:0] b_rdata,
  input  logic       clr_req,
  output logic       clr_done,
  output logic       busy,
  output logic       ram_rst,
  output logic       ram_w,
  output logic [2:0] ram_addr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);
  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, CLEAR} state_t;
  state_t state, state_n;
  logic owner, owner_n, ptr, ptr_n, pick_b;
  logic a_gnt_n, b_gnt_n, a_done_n, b_done_n, clr_done_n, ram_w_n;
  logic [2:0] ram_addr_n;
  logic [7:0] ram_din_n, a_rdata_n, b_rdata_n;
  // ptr = 1 means B was granted last, so A wins the next tie
  assign pick_b = b_req & (~a_req | ~ptr);
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n = ptr;
    a_gnt_n = 1'b0;
    b_gnt_n = 1'b0;
    a_done_n = 1'b0;
    b_done_n = 1'b0;
    clr_done_n = 1'b0;
    ram_w_n = 1'b0;
    ram_addr_n = ram_addr;
    ram_din_n = ram_din;
    a_rdata_n = a_rdata;
    b_rdata_n = b_rdata;
    case (state)
      IDLE: begin
        if (clr_req) state_n = CLEAR;
        else if (a_req | b_req) begin
          state_n = ISSUE;
          owner_n = pick_b;
          ptr_n = pick_b;
          a_gnt_n = ~pick_b;
          b_gnt_n = pick_b;
          ram_w_n = pick_b ? b_we : a_we;
          ram_addr_n = pick_b ? b_addr : a_addr;
          ram_din_n = pick_b ? b_wdata : a_wdata;
        end
      end
      ISSUE: begin
        state_n = ram_w ? IDLE : RWAIT;
        a_done_n = ram_w & ~owner;
        b_done_n = ram_w & owner;
      end
      RWAIT: begin
        state_n = IDLE;
        a_done_n = ~owner;
        b_done_n = owner;
        a_rdata_n = owner ? a_rdata : ram_dout;
        b_rdata_n = owner ? ram_dout : b_rdata;
      end
      default: begin
        state_n = IDLE;
        clr_done_n = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      ptr <= 1'b1;
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      clr_done <= 1'b0;
      busy <= 1'b0;
      ram_rst <= 1'b0;
      ram_w <= 1'b0;
      ram_addr <= '0;
      ram_din <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr <= ptr_n;
      a_gnt <= a_gnt_n;
      b_gnt <= b_gnt_n;
      a_done <= a_done_n;
      b_done <= b_done_n;
      a_rdata <= a_rdata_n;
      b_rdata <= b_rdata_n;
      clr_done <= clr_done_n;
      busy <= state_n != IDLE;
      ram_rst <= state_n == CLEAR;
      ram_w <= ram_w_n;
      ram_addr <= ram_addr_n;
      ram_din <= ram_din_n;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter driving a behavioural 8x8 synchronous ram.
module tb_ram_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0, clr_req = 0;
  logic [2:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic a_gnt, a_done, b_gnt, b_done, clr_done, busy, ram_rst, ram_w;
  logic [7:0] a_rdata, b_rdata, ram_din;
  logic [7:0] ram_dout = 8'h00;
  logic [2:0] ram_addr;
  logic [7:0] mem [8];
  int checks = 0, passed = 0;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
    .ram_rst(ram_rst), .ram_w(ram_w), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 8; i++) mem[i] = 8'hC3;

  always @(posedge clk) begin
    if (ram_rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      ram_dout <= 8'h00;
    end else begin
      if (ram_w) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit sel, input bit we, input logic [2:0] addr, input logic [7:0] data);
    if (sel) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = data; end
    else begin a_req = 1; a_we = we; a_addr = addr; a_wdata = data; end
  endtask

  task automatic do_write(input bit sel, input logic [2:0] addr, input logic [7:0] data);
    req(sel, 1, addr, data);
    tick();
    chk("wr_gnt", sel ? b_gnt : a_gnt, 1);
    chk("wr_ram_w", ram_w, 1);
    tick();
    chk("wr_done", sel ? b_done : a_done, 1);
    a_req = 0; b_req = 0;
  endtask

  task automatic do_read(input bit sel, input logic [2:0] addr, input logic [7:0] exp);
    req(sel, 0, addr, 8'h00);
    tick();
    chk("rd_gnt", sel ? b_gnt : a_gnt, 1);
    tick();
    chk("rd_early_done", sel ? b_done : a_done, 0);
    tick();
    chk("rd_done", sel ? b_done : a_done, 1);
    chk("rd_data", sel ? b_rdata : a_rdata, exp);
    a_req = 0; b_req = 0;
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {a_gnt, b_gnt, a_done, b_done, clr_done, ram_rst, ram_w}, 0);
    chk("rst_data", {a_rdata, b_rdata, ram_din, 5'd0, ram_addr}, 0);
    tick(); tick();
    rst = 0;
    req(0, 1, 3'd3, 8'h5A);
    tick();
    chk("a_gnt", a_gnt, 1);
    chk("ram_w", ram_w, 1);
    chk("ram_addr", ram_addr, 3);
    chk("ram_din", ram_din, 8'h5A);
    chk("busy_issue", busy, 1);
    tick();
    chk("a_done", a_done, 1);
    chk("ram_w_off", ram_w, 0);
    chk("busy_idle", busy, 0);
    a_req = 0;
    do_read(1, 3'd3, 8'h5A);
    // both requesters held high: grants must alternate
    req(0, 1, 3'd1, 8'h11);
    req(1, 1, 3'd2, 8'h22);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_a_gnt", a_gnt, (i % 2) == 0);
      chk("rr_b_gnt", b_gnt, (i % 2) == 1);
      tick();
      chk("rr_done", {a_done, b_done}, (i % 2) == 0 ? 2'b10 : 2'b01);
    end
    a_req = 0; b_req = 0;
    chk("rr_mem1", mem[1], 8'h11);
    chk("rr_mem2", mem[2], 8'h22);
    for (int i = 0; i < 8; i++) do_write(i[0], 3'(i), 8'hFF);
    clr_req = 1;
    tick();
    chk("clr_rst", ram_rst, 1);
    chk("clr_busy", busy, 1);
    tick();
    chk("clr_done", clr_done, 1);
    chk("clr_rst_off", ram_rst, 0);
    clr_req = 0;
    for (int i = 0; i < 8; i++) do_read(1, 3'(i), 8'h00);
    do_write(0, 3'd5, 8'h77);
    // clear raised while A's read sits in RWAIT, with B also pending
    req(0, 0, 3'd5, 8'h00);
    tick();
    chk("cr_a_gnt", a_gnt, 1);
    tick();
    clr_req = 1;
    req(1, 0, 3'd5, 8'h00);
    tick();
    chk("cr_a_done", a_done, 1);
    chk("cr_a_rdata", a_rdata, 8'h77);
    a_req = 0;
    tick();
    chk("cr_clear_first", {ram_rst, b_gnt}, 2'b10);
    tick();
    chk("cr_clr_done", clr_done, 1);
    clr_req = 0;
    tick();
    chk("cr_b_gnt", b_gnt, 1);
    tick(); tick();
    chk("cr_b_done", b_done, 1);
    chk("cr_b_rdata", b_rdata, 8'h00);
    b_req = 0;
    // reset in the ISSUE cycle of a write aborts it
    req(0, 1, 3'd0, 8'h33);
    tick();
    chk("ab_gnt", a_gnt, 1);
    rst = 1;
    #1;
    chk("ab_outs", {a_gnt, ram_w, busy, ram_rst}, 0);
    chk("ab_addr", {ram_din, 5'd0, ram_addr}, 0);
    tick();
    chk("ab_no_done", a_done, 0);
    a_req = 0;
    rst = 0;
    tick();
    chk("ab_no_done2", a_done, 0);
    do_read(1, 3'd0, 8'h00);
    // command is latched at grant; later address change is ignored
    req(0, 1, 3'd4, 8'h44);
    tick();
    chk("lat_gnt", a_gnt, 1);
    a_addr = 3'd6;
    chk("lat_addr", ram_addr, 4);
    tick();
    chk("lat_done", a_done, 1);
    a_req = 0;
    do_read(1, 3'd4, 8'h44);
    do_read(0, 3'd6, 8'h00);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin controller that shares the 8x8 synchronous `ram` block between requesters A and B and sequences its write, read and clear operations. It sits directly in front of the `ram` instance and drives all of the RAM's control and data inputs. Each requester gets a registered req/gnt/done handshake and its own read-data register. A separate clear command pulses the RAM's synchronous reset so that all eight words become zero.

## Interface
- No parameters. Data width 8, address width 3, both fixed to match `ram`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset of the controller only.
- `a_req`, `b_req` in 1: access request; held high until the matching `*_done`.
- `a_we`, `b_we` in 1: 1 = write, 0 = read.
- `a_addr`, `b_addr` in 3: word address.
- `a_wdata`, `b_wdata` in 8: write data.
- `a_gnt`, `b_gnt` out 1: one-cycle pulse when the command is latched.
- `a_done`, `b_done` out 1: one-cycle pulse when the access is complete.
- `a_rdata`, `b_rdata` out 8: last read result for that requester; holds until the next read by the same requester.
- `clr_req` in 1: request to zero the whole RAM; level signal, held until `clr_done`.
- `clr_done` out 1: one-cycle pulse when the clear is complete.
- `busy` out 1: high in every state except IDLE.
- `ram_rst` out 1: drives `ram.rst`.
- `ram_w` out 1: drives `ram.w`.
- `ram_addr` out 3: drives `ram.addr`.
- `ram_din` out 8: drives `ram.data_in`.
- `ram_dout` in 8: from `ram.data_out`.

## Operation
- All outputs are registered.
- Reset values: every output is 0, the FSM is in IDLE, and the round-robin pointer is set so that A wins the first tie.
- Asserting `rst` mid-operation aborts any in-flight access with no `done` pulse. RAM contents are untouched, because `ram_rst` is held at 0.
- FSM states: IDLE, ISSUE, RWAIT, CLEAR.
- **IDLE**
  - If `clr_req` is high, go to CLEAR. Clear has the highest priority.
  - Else, if any request is high, choose the winner. With one requester active, that requester wins. With both active, the requester not granted last wins.
  - Latch the winner's `we`, `addr` and `wdata` into `ram_w`, `ram_addr` and `ram_din`. Set the winner's `gnt` to 1, update the pointer, and go to ISSUE.
  - With no request, stay in IDLE with `ram_w` = 0.
- **ISSUE** (the RAM samples at the edge that ends this cycle)
  - Write: set the owner's `done` to 1, set `ram_w` to 0, go to IDLE.
  - Read: go to RWAIT. `ram_dout` updates at this edge.
- **RWAIT**
  - Capture `ram_dout` into the owner's `rdata`, set the owner's `done` to 1, go to IDLE.
- **CLEAR**
  - `ram_rst` is 1 for exactly this one cycle.
  - At the edge ending this cycle, set `ram_rst` to 0, set `clr_done` to 1, and go to IDLE.
- `ram_w` is 1 only during the ISSUE cycle of a write.
- `ram_addr` and `ram_din` hold their last value while idle.
- The command is latched at grant. Changes on the requester's `we`, `addr` or `wdata` after `gnt` are ignored.
- A requester may drop `req` before it is granted, which withdraws the request. Dropping `req` after grant does not cancel the access.
- The pointer changes only on a grant. Clears do not affect it.
- A requester must not re-raise `req` for a new access in the cycle its `done` is high. The controller samples `req` in that same IDLE cycle, so the requester drops `req` upon `done` and re-raises it in the following cycle.

## Timing
- Edge E0 samples `req` in IDLE. `gnt` is high in the cycle after E0; that cycle is ISSUE.
- **Write:** `done` is high 2 cycles after E0, coincident with IDLE.
- **Read:** `rdata` is valid and `done` is high 3 cycles after E0.
- Peak throughput: one write every 2 cycles or one read every 3 cycles. The IDLE cycle that carries `done` may accept the next grant.
- **Clear:** `ram_rst` is high in the cycle after sampling, and `clr_done` is high in the cycle after that.
- A clear requested during an access waits until the access finishes and is then taken ahead of any pending `req`.
- `busy` is 0 exactly in IDLE cycles.

## Test plan
- Reset, then A writes 0x5A to address 3 → `a_gnt` at +1, `ram_w`=1 with `ram_addr`=3 and `ram_din`=0x5A at +1, `a_done` at +2. Then B reads address 3 → `b_rdata`=0x5A with `b_done` 3 cycles after sampling.
- `a_req` and `b_req` both held high continuously with writes to addresses 1 and 2 → grants alternate A, B, A, B, starting with A after reset. No requester is granted twice in a row.
- Write 0xFF to all 8 addresses, assert `clr_req` → one-cycle `ram_rst`, then `clr_done`. Reads of addresses 0–7 all return 0x00.
- `clr_req` rises while a read by A is in RWAIT → A's read completes with correct data first. CLEAR is next, ahead of a pending `b_req`.
- Assert `rst` during the ISSUE cycle of A's write of 0x33 → all outputs go to 0 immediately and no `a_done` pulse occurs. After release, B's single request is granted normally.
- A changes `a_addr` from 4 to 6 in the cycle after `a_gnt` → the access still targets address 4.
